mac_rr_scheduler: RTL
=====================

Name: mac_rr_scheduler

Overview:
- Shares one multiply-add datapath (result = A*B + C) between two requesters using round-robin arbitration.
- Sequences each accepted operation through a fixed four-state FSM and returns the result on a single response channel tagged with the requester id.
- Sits between the operand producers and downstream logic that consumes SIZE_DATA_OUT-wide results.
- Default widths are taken from package_settings.

Parameters:
- SIZE_A, 8, width of operand A (unsigned).
- SIZE_B, 8, width of operand B (unsigned).
- SIZE_C, 16, width of addend C (unsigned).
- SIZE_DATA_OUT, 17, width of result.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a / req0_b / req0_c  in  SIZE_A / SIZE_B / SIZE_C  requester 0 operands.
- req1_valid  in  1  requester 1 has an operation pending.
- req1_ready  out  1  requester 1 operation accepted this cycle.
- req1_a / req1_b / req1_c  in  SIZE_A / SIZE_B / SIZE_C  requester 1 operands.
- rsp_valid  out  1  one-cycle pulse; rsp_data and rsp_id are valid.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  SIZE_DATA_OUT  A*B+C result.
- busy  out  1  high in every state except IDLE.
- op_count  out  CNT_W  number of completed operations.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=1 (so req0 wins the first tie).
  - req0_ready, req1_ready, rsp_valid, busy all 0.
  - rsp_id=0, rsp_data=0, op_count=0, internal operand and product registers 0.
- FSM states:
  - IDLE → MUL on accept; otherwise stays in IDLE.
  - MUL → ADD, unconditional.
  - ADD → DONE, unconditional.
  - DONE → IDLE, unconditional.
- Grant (combinational, meaningful only in IDLE):
  - Only reqN_valid high → grant N.
  - Both high → grant !last_grant.
  - Neither high → no grant.
- reqN_ready = (state==IDLE) && grant==N && reqN_valid. The two ready signals are never high together.
- Accept happens when reqN_valid && reqN_ready are high at a rising edge. On accept:
  - Latch a/b/c of requester N.
  - Set id_r=N and last_grant=N.
  - Go to MUL.
- Requesters must hold valid and operands stable until ready is seen. Valid dropped without ready is legal: the request is simply not taken.
- MUL: prod_r <= a_r*b_r, width SIZE_A+SIZE_B, unsigned.
- ADD: rsp_data <= zero-extended prod_r + zero-extended c_r.
  - The sum is computed at max(SIZE_A+SIZE_B, SIZE_C)+1 bits, then truncated to the low SIZE_DATA_OUT bits.
  - Defaults never overflow: maximum 130560 < 2^17.
- DONE:
  - rsp_valid=1 for exactly this one cycle; rsp_id=id_r.
  - op_count increments, wrapping modulo 2^CNT_W.
- rsp_data and rsp_id hold their values until the next ADD/DONE. There is no backpressure on the response.
- Latency: accept at edge t → rsp_valid high in cycle t+3. The earliest next accept is the edge ending cycle t+4. Throughput is 1 operation per 4 cycles.
- Starvation freedom: with both requesters continuously valid, grants alternate 0,1,0,1…
- Reset asserted in any state: the operation in flight is dropped, no rsp_valid pulse is emitted, and all reset values are restored on that edge.
- Valid changes while busy are ignored; arbitration is evaluated only in IDLE.

Test Plan:
- Single request: req0 a=3, b=4, c=5 → req0_ready pulses once; 3 cycles later rsp_valid=1, rsp_id=0, rsp_data=17, op_count=1.
- Maximum values: req1 a=255, b=255, c=65535 → rsp_data=130560 (0x1FE00), rsp_id=1; busy high for exactly 3 cycles after accept.
- Tie after reset: both valid (req0: 1,1,0; req1: 2,2,0) → req0 served first (result 1), then req1 (result 4); responses 4 cycles apart; ready signals never both high.
- Fairness: both requesters held valid for 8 operations → rsp_id sequence 0,1,0,1,0,1,0,1; op_count=8.
- Reset in MUL and again in ADD: → no rsp_valid pulse; all outputs 0 on the next cycle; next tie is granted to req0.
- Counter wrap: preload scenario with CNT_W=2, run 5 operations → op_count goes 1,2,3,0,1.

Source files
------------

// File: rtl/mac_rr_scheduler_if.sv
// Request/response bundle for the shared multiply-add scheduler.
// Two operand requesters in, one tagged result channel out.
interface mac_rr_scheduler_if #(
  parameter int unsigned SIZE_A        = 8,
  parameter int unsigned SIZE_B        = 8,
  parameter int unsigned SIZE_C        = 16,
  parameter int unsigned SIZE_DATA_OUT = 17,
  parameter int unsigned CNT_W         = 16
);
  logic                     req0_valid;
  logic                     req0_ready;
  logic [SIZE_A-1:0]        req0_a;
  logic [SIZE_B-1:0]        req0_b;
  logic [SIZE_C-1:0]        req0_c;

  logic                     req1_valid;
  logic                     req1_ready;
  logic [SIZE_A-1:0]        req1_a;
  logic [SIZE_B-1:0]        req1_b;
  logic [SIZE_C-1:0]        req1_c;

  logic                     rsp_valid;
  logic                     rsp_id;
  logic [SIZE_DATA_OUT-1:0] rsp_data;
  logic                     busy;
  logic [CNT_W-1:0]         op_count;

  modport master (
    output req0_valid, req0_a, req0_b, req0_c,
    output req1_valid, req1_a, req1_b, req1_c,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, busy, op_count
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_c,
    input  req1_valid, req1_a, req1_b, req1_c,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, busy, op_count
  );
endinterface

// File: rtl/mac_rr_scheduler.sv
// Round-robin scheduler sharing one A*B+C datapath between two requesters.
// Each accepted operation walks IDLE -> MUL -> ADD -> DONE; result is tagged with the requester id.
module mac_rr_scheduler #(
  parameter int unsigned SIZE_A        = 8,
  parameter int unsigned SIZE_B        = 8,
  parameter int unsigned SIZE_C        = 16,
  parameter int unsigned SIZE_DATA_OUT = 17,
  parameter int unsigned CNT_W         = 16
) (
  input logic               clk,
  input logic               reset,
  mac_rr_scheduler_if.slave bus
);

  localparam int unsigned PROD_W = SIZE_A + SIZE_B;
  localparam int unsigned SUM_W  = ((PROD_W > SIZE_C) ? PROD_W : SIZE_C) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                   state_q;
  logic                     last_grant_q;
  logic                     id_q;
  logic [SIZE_A-1:0]        a_q;
  logic [SIZE_B-1:0]        b_q;
  logic [SIZE_C-1:0]        c_q;
  logic [PROD_W-1:0]        prod_q;
  logic                     rsp_valid_q;
  logic                     rsp_id_q;
  logic [SIZE_DATA_OUT-1:0] rsp_data_q;
  logic                     busy_q;
  logic [CNT_W-1:0]         op_count_q;

  logic                     ready0_c;
  logic                     ready1_c;
  logic [SUM_W-1:0]         sum_c;

  // Grant: a lone requester wins; on a tie the one not served last time wins.
  always_comb begin
    ready0_c = 1'b0;
    ready1_c = 1'b0;
    if (state_q == ST_IDLE) begin
      ready0_c = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      ready1_c = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    end
  end

  assign sum_c = SUM_W'(prod_q) + SUM_W'(c_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      prod_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
      op_count_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ready0_c || ready1_c) begin
            a_q          <= ready1_c ? bus.req1_a : bus.req0_a;
            b_q          <= ready1_c ? bus.req1_b : bus.req0_b;
            c_q          <= ready1_c ? bus.req1_c : bus.req0_c;
            id_q         <= ready1_c;
            last_grant_q <= ready1_c;
            busy_q       <= 1'b1;
            state_q      <= ST_MUL;
          end
        end
        ST_MUL: begin
          prod_q  <= PROD_W'(a_q) * PROD_W'(b_q);
          state_q <= ST_ADD;
        end
        // Result, tag and count land together so they are visible during DONE.
        ST_ADD: begin
          rsp_data_q  <= SIZE_DATA_OUT'(sum_c);
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          op_count_q  <= op_count_q + CNT_W'(1);
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = ready0_c;
  assign bus.req1_ready = ready1_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = busy_q;
  assign bus.op_count   = op_count_q;

endmodule
